// File: rtl/fdc_multi.sv
// fdc_multi: multi-channel frequency-to-digital converter.
// Counts synchronised edges per channel over a gate window and latches saturating results.
module fdc_multi #(
    parameter int CHANNELS    = 2,
    parameter int CNT_W       = 16,
    parameter int GATE_W      = 16,
    parameter int SYNC_STAGES = 2,
    localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                start,
    input  logic                continuous,
    input  logic                mode,
    input  logic [GATE_W-1:0]   gate_len,
    input  logic [CHANNELS-1:0] sig_in,
    input  logic [SEL_W-1:0]    sel,
    output logic [CNT_W-1:0]    count_out,
    output logic                valid,
    output logic                busy,
    output logic [CHANNELS-1:0] overflow
);

    // state    | meaning
    // ST_IDLE  | waiting for en & (start | continuous)
    // ST_COUNT | gate window open, accumulators counting qualified edges
    // ST_DONE  | results just latched, valid high, dead cycle before re-arm
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              r_state;
    logic [GATE_W-1:0]   r_gate;
    logic [CNT_W-1:0]    r_acc    [CHANNELS];
    logic [CNT_W-1:0]    r_result [CHANNELS];
    logic [CHANNELS-1:0] r_ov_work;
    logic [CHANNELS-1:0] r_overflow;
    logic                r_valid;
    logic                r_busy;

    logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
    logic [CHANNELS-1:0] r_hist;
    logic [CHANNELS-1:0] w_sync_out;
    logic [CHANNELS-1:0] w_evt;
    logic [CNT_W-1:0]    w_acc_nxt [CHANNELS];
    logic [CHANNELS-1:0] w_sat;
    logic [GATE_W-1:0]   w_gate_load;

    assign w_sync_out  = r_sync[SYNC_STAGES-1];
    assign w_evt       = mode ? (w_sync_out ^ r_hist) : (w_sync_out & ~r_hist);
    assign w_gate_load = (gate_len == '0) ? GATE_W'(1) : gate_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_hist <= '0;
        end else begin
            r_sync[0] <= sig_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_hist <= w_sync_out;
        end
    end

    // Saturating increment; w_sat marks an edge lost at full scale.
    always_comb begin
        w_sat = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_acc_nxt[c] = r_acc[c];
            if (w_evt[c]) begin
                if (r_acc[c] == CNT_MAX) w_sat[c] = 1'b1;
                else                     w_acc_nxt[c] = r_acc[c] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gate     <= '0;
            r_ov_work  <= '0;
            r_overflow <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_acc[c]    <= '0;
                r_result[c] <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (en && (start || continuous)) begin
                        r_state   <= ST_COUNT;
                        r_busy    <= 1'b1;
                        r_gate    <= w_gate_load;
                        r_ov_work <= '0;
                        for (int c = 0; c < CHANNELS; c++) r_acc[c] <= '0;
                    end
                end
                ST_COUNT: begin
                    if (!en) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_gate == GATE_W'(1)) begin
                        r_state    <= ST_DONE;
                        r_valid    <= 1'b1;
                        r_overflow <= r_ov_work | w_sat;
                        for (int c = 0; c < CHANNELS; c++) r_result[c] <= w_acc_nxt[c];
                    end else begin
                        r_gate    <= r_gate - GATE_W'(1);
                        r_ov_work <= r_ov_work | w_sat;
                        for (int c = 0; c < CHANNELS; c++) r_acc[c] <= w_acc_nxt[c];
                    end
                end
                ST_DONE: begin
                    if (en && continuous) begin
                        r_state   <= ST_COUNT;
                        r_gate    <= w_gate_load;
                        r_ov_work <= '0;
                        for (int c = 0; c < CHANNELS; c++) r_acc[c] <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        count_out = '0;
        if (int'(sel) < CHANNELS) count_out = r_result[sel];
    end

    assign valid    = r_valid;
    assign busy     = r_busy;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_fdc_multi.sv
// tb_fdc_multi: scoreboard bench for fdc_multi; windows are predicted from the recorded
// input history by counting transitions that fall inside each gate window.
module tb_fdc_multi;

    localparam int CH   = 3;
    localparam int CW   = 8;
    localparam int GW   = 16;
    localparam int S    = 2;
    localparam int SW   = 2;
    localparam int CMAX = (1 << CW) - 1;
    localparam int HMAX = 20000;

    logic          clk = 1'b0;
    logic          rst, en, start, continuous, mode;
    logic [GW-1:0] gate_len;
    logic [CH-1:0] sig_in;
    logic [SW-1:0] sel;
    logic [CW-1:0] count_out;
    logic          valid, busy;
    logic [CH-1:0] overflow;

    fdc_multi #(.CHANNELS(CH), .CNT_W(CW), .GATE_W(GW), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .continuous(continuous),
        .mode(mode), .gate_len(gate_len), .sig_in(sig_in), .sel(sel),
        .count_out(count_out), .valid(valid), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { int c0; int n; bit md; } win_t;
    win_t exp_q[$];

    int            last_res [CH];
    logic [CH-1:0] ov_exp;
    logic [CH-1:0] sig_hist [0:HMAX-1];

    int kind [CH];   // 0 static level, 1 random per cycle, 2 square wave
    int per  [CH];
    int phase[CH];
    bit lvl  [CH];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit gen_bit(input int c, input int k);
        case (kind[c])
            0:       return lvl[c];
            1:       return 1'($urandom_range(0, 1));
            default: return 1'(((k + phase[c]) / (per[c] / 2)) % 2);
        endcase
    endfunction

    // Number of qualified transitions seen by a window that opened at edge c0 and lasts n edges.
    function automatic int model_cnt(input int ch, input int c0, input int n, input bit md);
        int cnt = 0;
        for (int j = c0 + 1 - S; j <= c0 + n - S; j++) begin
            bit a = sig_hist[j-1][ch];
            bit b = sig_hist[j][ch];
            if (md ? (a != b) : (!a && b)) cnt++;
        end
        return cnt;
    endfunction

    // input driver: value driven after edge k is sampled at edge k+1
    initial begin
        logic [CH-1:0] v;
        sig_in = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int c = 0; c < CH; c++) v[c] = gen_bit(c, ecnt + 1);
            sig_in = v;
            if (ecnt + 1 < HMAX) sig_hist[ecnt + 1] = v;
        end
    end

    // monitor
    always @(negedge clk) begin
        win_t w;
        int raw;
        if (!rst && valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                w = exp_q.pop_front();
                check("valid_time", ecnt, w.c0 + w.n);
                for (int c = 0; c < CH; c++) begin
                    raw         = model_cnt(c, w.c0, w.n, w.md);
                    last_res[c] = (raw > CMAX) ? CMAX : raw;
                    ov_exp[c]   = (raw > CMAX);
                end
                check("overflow", overflow, ov_exp);
                check("count_sel", count_out, (int'(sel) < CH) ? last_res[sel] : 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int c, input int k, input int p, input int ph, input bit l);
        kind[c] = k; per[c] = p; phase[c] = ph; lvl[c] = l;
    endtask

    task automatic issue(input int g, input bit md, input bit do_push, input bit cont);
        step();
        gate_len   = GW'(g);
        mode       = md;
        continuous = cont;
        start      = 1'b1;
        if (do_push) exp_q.push_back('{ecnt + 1, (g == 0) ? 1 : g, md});
        step();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (valid) begin
                seen = 1;
                break;
            end
        end
        check("valid_seen", seen, 1);
    endtask

    task automatic sweep();
        for (int s = 0; s < 4; s++) begin
            sel = SW'(s);
            #1;
            check("hold_sel", count_out, (s < CH) ? last_res[s] : 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int g;
        bit md;
        for (int i = 0; i < HMAX; i++) sig_hist[i] = '0;
        for (int c = 0; c < CH; c++) begin
            cfg(c, 0, 2, 0, 0);
            last_res[c] = 0;
        end
        ov_exp = '0;
        rst = 1'b1; en = 1'b1; start = 1'b0; continuous = 1'b0; mode = 1'b0;
        gate_len = '0; sel = '0;

        @(negedge clk);
        check("rst_count", count_out, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;
        repeat (5) step();

        // basic window, rising edges
        cfg(0, 2, 8, 0, 0); cfg(1, 2, 16, 3, 0); cfg(2, 1, 2, 0, 0);
        repeat (4) step();
        issue(80, 0, 1, 0);
        wait_valid(100);
        sweep();
        sel = 2'd0; #1; check("t1_ch0", count_out, 10);
        sel = 2'd1; #1; check("t1_ch1", count_out, 5);

        // abort by en low mid-window
        issue(80, 0, 0, 0);
        repeat (30) step();
        en = 1'b0;
        step();
        check("abort_busy", busy, 0);
        en = 1'b1;
        repeat (3) step();
        sel = 2'd0; #1; check("abort_hold0", count_out, 10);
        sel = 2'd1; #1; check("abort_hold1", count_out, 5);
        check("abort_ovf", overflow, ov_exp);

        // both edges, busy length
        issue(80, 1, 1, 0);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) cnt++;
            else break;
        end
        check("busy_cycles", cnt, 81);
        sweep();
        sel = 2'd0; #1; check("t2_ch0", count_out, 20);
        sel = 2'd1; #1; check("t2_ch1", count_out, 10);

        // saturation
        cfg(0, 2, 2, 0, 0); cfg(1, 0, 2, 0, 0); cfg(2, 0, 2, 0, 1);
        repeat (4) step();
        sel = 2'd0;
        issue(400, 1, 1, 0);
        wait_valid(420);
        sweep();
        sel = 2'd0; #1; check("sat_ch0", count_out, CMAX);
        check("sat_ovf", overflow, 3'b001);

        // continuous re-arm, three windows then stop
        cfg(0, 2, 8, 1, 0); cfg(1, 1, 2, 0, 0); cfg(2, 2, 6, 0, 0);
        repeat (4) step();
        sel = 2'd0;
        step();
        gate_len = GW'(40); mode = 1'b0; continuous = 1'b1; start = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back('{ecnt + 1 + i * 41, 40, 1'b0});
        step();
        start = 1'b0;
        wait_valid(60); #1; check("cont_ch0_a", count_out, 5);
        wait_valid(60); #1; check("cont_ch0_b", count_out, 5);
        step();
        continuous = 1'b0;
        wait_valid(60); #1; check("cont_ch0_c", count_out, 5);
        repeat (100) step();
        check("cont_idle", busy, 0);

        // start while busy, and start with en low
        issue(60, 0, 1, 0);
        repeat (20) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_valid(80);
        step();
        en = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        check("start_en_low", busy, 0);
        en = 1'b1;
        repeat (3) step();

        // asynchronous reset mid-window
        issue(80, 0, 1, 0);
        repeat (50) step();
        #2 rst = 1'b1;
        #1;
        check("mrst_valid", valid, 0);
        check("mrst_busy", busy, 0);
        check("mrst_ovf", overflow, 0);
        check("mrst_count", count_out, 0);
        exp_q.delete();
        for (int c = 0; c < CH; c++) last_res[c] = 0;
        ov_exp = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        sweep();
        repeat (6) step();

        // zero gate length
        issue(0, 1, 1, 0);
        wait_valid(5);
        repeat (3) step();

        // randomized windows
        for (int r = 0; r < 12; r++) begin
            for (int c = 0; c < CH; c++)
                cfg(c, $urandom_range(0, 2), 2 * $urandom_range(1, 10),
                    $urandom_range(0, 19), 1'($urandom_range(0, 1)));
            repeat (3) step();
            sel = SW'($urandom_range(0, 3));
            g   = $urandom_range(0, 100);
            md  = 1'($urandom_range(0, 1));
            issue(g, md, 1, 0);
            wait_valid(g + 10);
            sweep();
            step();
        end

        repeat (10) step();
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
